// File: rtl/uart_tx_mmio_if.sv
// CPU data-memory bus slice seen by the UART transmitter peripheral.
// Latency: none; this is a bundle of wires, read data is combinational in the slave.
// Backpressure: none; stores are fire-and-forget, a full queue drops data in the slave.
interface uart_tx_mmio_if;
  logic [31:0] rw_addr;
  logic [31:0] w_data;
  logic        w_en;
  logic [31:0] r_data;
  logic        r_hit;

  modport master (
    output rw_addr, w_data, w_en,
    input  r_data, r_hit
  );

  modport slave (
    input  rw_addr, w_data, w_en,
    output r_data, r_hit
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO and a status word.
// Latency: a push at edge k starts the START bit after edge k+1 when idle; a frame is 10*CLKS_PER_BIT cycles.
// Backpressure: none on the bus; a push into a full FIFO without a same-cycle pop is dropped and sets sticky ovf.
module uart_tx_mmio #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] DATA_ADDR    = 32'h0000_03f0,
  parameter logic [31:0] STAT_ADDR    = 32'h0000_03f4
) (
  input  logic           clock,
  input  logic           rst_n,
  uart_tx_mmio_if.slave  bus,
  output logic           tx,
  output logic           irq_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q;
  logic [BW-1:0]   baud_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            tx_q;
  logic            irq_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;

  logic            push_req, push_ok, pop, clr_req;
  logic            fifo_empty, fifo_full, baud_last, busy;
  logic [31:0]     status;

  // Only the low byte of a data store is transmitted; the rest has no meaning here.
  logic            unused_wdata_hi;
  assign unused_wdata_hi = ^bus.w_data[31:8];

  // Bus decode, FIFO accept/pop decisions and sticky overflow next-state.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DEPTH_C);
    baud_last  = (baud_q == BAUD_LAST);
    push_req   = bus.w_en && (bus.rw_addr == DATA_ADDR);
    clr_req    = bus.w_en && (bus.rw_addr == STAT_ADDR) && bus.w_data[3];
    // The FSM takes the head byte when leaving IDLE or at the last STOP cycle.
    pop        = !fifo_empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_last));
    // A same-cycle pop frees a slot, so a full FIFO can still accept.
    push_ok    = push_req && (!fifo_full || pop);
    count_d    = count_q + CW'(push_ok) - CW'(pop);
    ovf_d      = ovf_q;
    if (clr_req)              ovf_d = 1'b0;
    // Overflow is applied last so it wins over a simultaneous clear.
    if (push_req && !push_ok) ovf_d = 1'b1;
  end

  // FIFO pointers, occupancy and overflow flag.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.w_data[7:0];
  end

  // Serialiser FSM with registered line output and empty interrupt.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      irq_q     <= 1'b1;
    end else begin
      irq_q <= (state_q == S_IDLE) && fifo_empty;
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= S_DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              // Present the next bit together with the shift so tx stays registered.
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (pop) begin
              // Chain straight into the next START bit with no idle gap.
              shift_q <= mem_q[rd_ptr_q];
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Status word and read-path decode, combinational from address and registers.
  always_comb begin
    busy       = (state_q != S_IDLE) || !fifo_empty;
    status     = {24'h0, 4'(count_q), ovf_q, fifo_empty, fifo_full, busy};
    bus.r_hit  = (bus.rw_addr == STAT_ADDR);
    bus.r_data = bus.r_hit ? status : 32'h0;
  end

  assign tx        = tx_q;
  assign irq_empty = irq_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Latency: stimulus driven after falling edges, line and irq logged 1ns after rising edges.
// Backpressure: none; overflow and coincident push/pop corners are driven explicitly.
module tb_uart_tx_mmio;

  localparam logic [31:0] DADDR = 32'h0000_03f0;
  localparam logic [31:0] SADDR = 32'h0000_03f4;
  localparam logic [31:0] XADDR = 32'h0000_03f8;

  logic clock = 1'b0;
  logic rst_n;
  logic tx, irq_empty, tx2, irq2;

  always #5 clock = ~clock;

  uart_tx_mmio_if bus ();
  uart_tx_mmio_if bus2 ();

  uart_tx_mmio #(
    .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .DATA_ADDR(DADDR), .STAT_ADDR(SADDR)
  ) dut (
    .clock(clock), .rst_n(rst_n), .bus(bus), .tx(tx), .irq_empty(irq_empty)
  );

  // Second instance maps data and status to one address so a store can
  // overflow and clear in the same cycle.
  uart_tx_mmio #(
    .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .DATA_ADDR(XADDR), .STAT_ADDR(XADDR)
  ) dut2 (
    .clock(clock), .rst_n(rst_n), .bus(bus2), .tx(tx2), .irq_empty(irq2)
  );

  // Entry i holds the value seen just after rising edge i.
  logic tx_log[$];
  logic irq_log[$];

  initial begin
    forever begin
      @(posedge clock);
      #1;
      tx_log.push_back(tx);
      irq_log.push_back(irq_empty);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  // One bus cycle; k is the index of the rising edge that samples it.
  // Afterwards the address is parked on the status register.
  task automatic bus_op(input logic en, input logic [31:0] addr, input logic [31:0] data,
                        output int k);
    bus.w_en    = en;
    bus.rw_addr = addr;
    bus.w_data  = data;
    k = tx_log.size();
    cyc();
    bus.w_en    = 1'b0;
    bus.rw_addr = SADDR;
    bus.w_data  = 32'h0;
    #1;
  endtask

  task automatic wait_until(input int n_entries);
    while (tx_log.size() < n_entries) cyc();
  endtask

  task automatic do_reset();
    bus.w_en = 1'b0;  bus.rw_addr = 32'h0;  bus.w_data = 32'h0;
    bus2.w_en = 1'b0; bus2.rw_addr = 32'h0; bus2.w_data = 32'h0;
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // Expected 8N1 waveform, four samples per bit, sample j in bit j.
  function automatic logic [39:0] frame_bits(input logic [7:0] b);
    logic [39:0] f;
    logic        v;
    f = '0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      v = 1'b0;
      else if (i == 9) v = 1'b1;
      else             v = b[i-1];
      for (int j = 0; j < 4; j++) f[i*4+j] = v;
    end
    return f;
  endfunction

  task automatic check_frame(input string name, input int start, input logic [7:0] b);
    logic [39:0] act;
    wait_until(start + 40);
    for (int j = 0; j < 40; j++) act[j] = tx_log[start+j];
    check(name, act, frame_bits(b));
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        exp_hit;
    logic [31:0] exp_data;
  } rd_vec_t;

  typedef struct {
    logic        en;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_stat;
  } op_vec_t;

  rd_vec_t rd_tbl[5];
  op_vec_t op_tbl[9];

  initial begin
    int k, k0, k6, k2;
    logic [19:0] idle_bits;
    logic [7:0]  cbytes[6];

    rd_tbl[0] = '{SADDR,          1'b1, 32'h0000_0004};
    rd_tbl[1] = '{DADDR,          1'b0, 32'h0};
    rd_tbl[2] = '{XADDR,          1'b0, 32'h0};
    rd_tbl[3] = '{32'h0,          1'b0, 32'h0};
    rd_tbl[4] = '{32'h0000_13f4,  1'b0, 32'h0};

    op_tbl[0] = '{1'b1, DADDR, 32'hFFFF_FF01, 32'h11};
    op_tbl[1] = '{1'b1, DADDR, 32'h0000_0002, 32'h11};
    op_tbl[2] = '{1'b1, DADDR, 32'h0000_AB03, 32'h21};
    op_tbl[3] = '{1'b1, DADDR, 32'h0000_0004, 32'h31};
    op_tbl[4] = '{1'b1, DADDR, 32'h0000_0005, 32'h43};
    op_tbl[5] = '{1'b1, DADDR, 32'h0000_0006, 32'h4B};
    op_tbl[6] = '{1'b1, SADDR, 32'h0000_00F7, 32'h4B};
    op_tbl[7] = '{1'b1, SADDR, 32'h0000_0008, 32'h43};
    op_tbl[8] = '{1'b1, XADDR, 32'h0000_0006, 32'h43};

    cbytes = '{8'hA1, 8'h12, 8'h34, 8'hC8, 8'h0F, 8'h96};

    // Reset state and read decode
    do_reset();
    cyc();
    check("reset_tx", tx, 1'b1);
    check("reset_irq", irq_empty, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.rw_addr = rd_tbl[i].addr;
      #1;
      check($sformatf("rd_hit[%0d]", i), bus.r_hit, rd_tbl[i].exp_hit);
      check($sformatf("rd_data[%0d]", i), bus.r_data, rd_tbl[i].exp_data);
    end
    cyc();

    // Single frame 0x55 from idle
    bus_op(1'b1, DADDR, 32'hFFFF_FF55, k);
    check_frame("frame_55", k + 1, 8'h55);
    check("pre_start_55", tx_log[k], 1'b1);
    wait_until(k + 43);
    check("irq_in_stop", irq_log[k+41], 1'b0);
    check("irq_after_stop", irq_log[k+42], 1'b1);

    // Queue fill, overflow, clear, foreign address
    do_reset();
    k0 = 0;
    for (int i = 0; i < 9; i++) begin
      bus_op(op_tbl[i].en, op_tbl[i].addr, op_tbl[i].data, k);
      if (i == 0) k0 = k;
      check($sformatf("op_stat[%0d]", i), bus.r_data, op_tbl[i].exp_stat);
    end
    for (int j = 0; j < 5; j++)
      check_frame($sformatf("b2b_frame[%0d]", j), k0 + 1 + 40*j, 8'(j + 1));
    wait_until(k0 + 221);
    for (int j = 0; j < 20; j++) idle_bits[j] = tx_log[k0+201+j];
    check("no_sixth_frame", idle_bits, 20'hFFFFF);
    bus.rw_addr = SADDR;
    #1;
    check("final_stat", bus.r_data, 32'h0000_0004);
    cyc();

    // Push into a full FIFO on the STOP->START pop edge
    do_reset();
    bus_op(1'b1, DADDR, {24'h0, cbytes[0]}, k);
    for (int i = 1; i < 5; i++) bus_op(1'b1, DADDR, {24'h0, cbytes[i]}, k6);
    wait_until(k + 41);
    bus_op(1'b1, DADDR, {24'h0, cbytes[5]}, k6);
    check("coincide_stat", bus.r_data, 32'h0000_0043);
    for (int j = 0; j < 6; j++)
      check_frame($sformatf("coincide_frame[%0d]", j), k + 1 + 40*j, cbytes[j]);

    // Reset mid-DATA, then recover
    do_reset();
    bus_op(1'b1, DADDR, 32'h0000_00A5, k);
    wait_until(k + 11);
    check("mid_data_tx_low", tx, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", tx, 1'b1);
    check("rst_mid_stat", bus.r_data, 32'h0000_0004);
    check("rst_mid_irq", irq_empty, 1'b1);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    bus_op(1'b1, DADDR, 32'h0000_003C, k2);
    check("pre_start_3c", tx_log[k2], 1'b1);
    check_frame("frame_3c", k2 + 1, 8'h3C);

    // Overflow and clear in one store: the set must win
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus2.w_en    = 1'b1;
      bus2.rw_addr = XADDR;
      bus2.w_data  = 32'h0000_0008;
      cyc();
    end
    bus2.w_en = 1'b0;
    #1;
    check("set_wins_hit", bus2.r_hit, 1'b1);
    check("set_wins_stat", bus2.r_data, 32'h0000_004B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter peripheral on the CPU data-memory bus, next to the LED8 peripheral. The CPU writes bytes to a data address. They are queued in a small FIFO and serialised as 8N1 frames on `tx`. A status word is readable at a second address. The top level muxes `r_data` into the CPU read path whenever `r_hit` is 1, the same way it does for the LED state register.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: `clock` cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, default 4: FIFO entries; must be a power of 2 and ≥ 2.
- `DATA_ADDR`, default 32'h0000_03f0: write here to enqueue a byte.
- `STAT_ADDR`, default 32'h0000_03f4: read status here; write here to clear flags.

Ports:
- `clock` in, 1: the single clock; all logic is clocked on its rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `rw_addr` in, 32: CPU data address.
- `w_data` in, 32: CPU store data (the rs2 value).
- `w_en` in, 1: CPU store strobe.
- `r_data` out, 32: status word. Combinational. Valid when `r_hit` is 1, 0 otherwise.
- `r_hit` out, 1: combinational; equals (`rw_addr == STAT_ADDR`).
- `tx` out, 1: serial line, registered, idles high.
- `irq_empty` out, 1: registered; 1 when the FIFO is empty and the FSM is IDLE.

## Operation
- Push: when `w_en` is 1 and `rw_addr == DATA_ADDR`, `w_data[7:0]` is enqueued. `w_data[31:8]` is ignored.
- A push is accepted if count < `FIFO_DEPTH`, or if a pop occurs in the same cycle.
- A rejected push drops the byte and sets the sticky `ovf` flag.
- Clear: a store to `STAT_ADDR` with `w_data[3] = 1` clears `ovf`. If an overflowing push occurs in the same cycle, the set wins.
- Status word layout:
  - bit0 `busy`: FSM is not IDLE or the FIFO is not empty.
  - bit1 `full`: count == `FIFO_DEPTH`.
  - bit2 `empty`: count == 0.
  - bit3 `ovf`.
  - bits[7:4]: count, zero-extended.
  - bits[31:8]: 0.
- FIFO: circular buffer. Read and write pointers are log2(`FIFO_DEPTH`) bits and wrap modulo depth. The count register is log2(`FIFO_DEPTH`)+1 bits.
- FSM states: IDLE, START, DATA, STOP. A baud counter counts 0..`CLKS_PER_BIT`-1 and a bit index counts 0..7.
  - IDLE: `tx` = 1. If the FIFO is not empty, pop the head into the shift register, clear the baud counter, go to START.
  - START: `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index = 0.
  - DATA: `tx` = shift[0] for `CLKS_PER_BIT` cycles, then shift right.
    - If bit index == 7, go to STOP; otherwise increment bit index.
    - Bits are sent LSB first.
  - STOP: `tx` = 1 for `CLKS_PER_BIT` cycles. At the end:
    - If the FIFO is not empty, pop the next byte and go directly to START, with no idle gap.
    - Otherwise go to IDLE.
- Stores to any other address are ignored. Reads have no side effects.

## Timing
- Reset values:
  - `tx` = 1, `irq_empty` = 1.
  - FSM = IDLE, count = 0, pointers = 0, `ovf` = 0, baud counter and bit index = 0.
  - Reset applies immediately, including mid-frame; `tx` goes high asynchronously.
- A push is captured at rising edge k, and `empty` deasserts after edge k.
- From IDLE, the pop and the transition to START happen at edge k+1, so `tx` falls after edge k+1 (one-cycle latency).
- A frame lasts exactly 10 × `CLKS_PER_BIT` cycles.
- Back-to-back frames run with no gap between the STOP bit and the next START bit.
- Popping at the STOP-to-START or IDLE-to-START edge and pushing in the same cycle leaves the count unchanged.
- `r_data` and `r_hit` are combinational from `rw_addr` and the current registers. A store is reflected in the status word from the next cycle.
- `irq_empty` rises one cycle after the FSM returns to IDLE with the FIFO empty.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4 and `FIFO_DEPTH` = 4.
- Reset, then no stimulus → `tx` = 1, `irq_empty` = 1, status read at 0x3f4 returns 32'h0000_0004.
- Store 32'hFFFF_FF55 to 0x3f0 → `tx` low 4 cycles starting the edge after the push, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; `irq_empty` rises after the STOP bit.
- Five consecutive stores (0x01..0x05) while the line is idle → the first byte pops after one cycle, so 4 remain and none is dropped. A sixth store before any further pop → `ovf` = 1 and status = 32'h0000_004B. All five frames are sent back-to-back over 200 cycles with no gap, and byte 0x06 is never sent.
- Store 32'h8 to 0x3f4 after an overflow → `ovf` = 0. Store 32'h8 to 0x3f4 in the same cycle as an overflowing push → `ovf` stays 1.
- Push when full, coincident with the STOP→START pop → push accepted, count stays 4, `ovf` stays 0.
- Assert `rst_n` = 0 mid-DATA for byte 0xA5 → `tx` = 1 immediately, FIFO empty. After release, a new push of 0x3C transmits correctly from START.
